// File: rtl/ucsbece154a_mccontroller_if.sv
// ucsbece154a_mccontroller_if
// Control bus between the multicycle datapath and its controller.
//   Datapath -> controller : op_i, funct3_i, funct7b5_i (IR fields),
//                            zero_i (ALU flag), memready_i (memory handshake)
//   Controller -> datapath : register enables, mux selects, ALUControl_o,
//                            ImmSrc_o, RegWrite_o, state_o (debug)
// Modports: master = datapath side, slave = controller side.
interface ucsbece154a_mccontroller_if;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       zero_i;
  logic       memready_i;

  logic       PCWrite_o;
  logic       AdrSrc_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic [1:0] ResultSrc_o;
  logic [1:0] ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALUControl_o;
  logic [2:0] ImmSrc_o;
  logic       RegWrite_o;
  logic [3:0] state_o;

  modport master (
    output op_i, funct3_i, funct7b5_i, zero_i, memready_i,
    input  PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o,
           ALUSrcA_o, ALUSrcB_o, ALUControl_o, ImmSrc_o, RegWrite_o, state_o
  );

  modport slave (
    input  op_i, funct3_i, funct7b5_i, zero_i, memready_i,
    output PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o,
           ALUSrcA_o, ALUSrcB_o, ALUControl_o, ImmSrc_o, RegWrite_o, state_o
  );
endinterface

// File: rtl/ucsbece154a_mccontroller.sv
// ucsbece154a_mccontroller
// Moore control FSM for the multicycle RISC-V core: walks the shared datapath
// (one ALU, one unified memory port, PC/IR/OldPC/A/Data/ALUOut registers)
// through one instruction at a time, stalling on memready_i in Fetch,
// MemRead and MemWrite.
// Ports:
//   clk     - rising-edge clock
//   reset_n - synchronous active-low reset; while low, all write enables are
//             held at 0 and the remaining outputs show Fetch values
//   bus     - controller side (slave) of ucsbece154a_mccontroller_if
// Build option: define UCSBECE154A_BNE_EN to make funct3 001 in the branch
// state take the branch on a non-zero ALU result (bne).
module ucsbece154a_mccontroller (
  input  logic                          clk,
  input  logic                          reset_n,
  ucsbece154a_mccontroller_if.slave     bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALUcontrol_add = 3'b000;
  localparam logic [2:0] ALUcontrol_sub = 3'b001;
  localparam logic [2:0] ALUcontrol_and = 3'b010;
  localparam logic [2:0] ALUcontrol_or  = 3'b011;
  localparam logic [2:0] ALUcontrol_slt = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  state_t     state_q, state_d, cur_state;
  logic       pc_update, branch, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] alu_ctrl, imm_src;
  logic       br_cond;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // During reset the outputs decode as Fetch, so the datapath sees a clean
  // Fetch setup on the cycle reset is released.
  always_comb begin
    cur_state  = reset_n ? state_q : S_FETCH;
    state_d    = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (cur_state)
      S_FETCH: begin
        ir_write   = bus.memready_i;
        pc_update  = bus.memready_i;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = bus.memready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut for a possible branch.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_FETCH; // unsupported: retire as NOP
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = bus.memready_i ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = bus.memready_i ? S_FETCH : S_MEMWRITE;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        // PC+4 computed here from OldPC, written back in ALUWB.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

`ifdef UCSBECE154A_BNE_EN
  assign br_cond = (bus.funct3_i == 3'b001) ? ~bus.zero_i : bus.zero_i;
`else
  assign br_cond = bus.zero_i;
`endif

  always_comb begin
    alu_ctrl = ALUcontrol_add;
    case (alu_op)
      2'b01: alu_ctrl = ALUcontrol_sub;
      2'b10: begin
        case (bus.funct3_i)
          3'b000:  alu_ctrl = (bus.funct7b5_i & bus.op_i[5]) ? ALUcontrol_sub
                                                             : ALUcontrol_add;
          3'b010:  alu_ctrl = ALUcontrol_slt;
          3'b110:  alu_ctrl = ALUcontrol_or;
          3'b111:  alu_ctrl = ALUcontrol_and;
          default: alu_ctrl = ALUcontrol_add;
        endcase
      end
      default: alu_ctrl = ALUcontrol_add;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (bus.op_i)
      OP_SW:   imm_src = 3'b001;
      OP_BR:   imm_src = 3'b010;
      OP_JAL:  imm_src = 3'b011;
      OP_LUI:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
  end

  assign bus.PCWrite_o    = reset_n & (pc_update | (branch & br_cond));
  assign bus.IRWrite_o    = reset_n & ir_write;
  assign bus.MemWrite_o   = reset_n & mem_write;
  assign bus.RegWrite_o   = reset_n & reg_write;
  assign bus.AdrSrc_o     = adr_src;
  assign bus.ResultSrc_o  = result_src;
  assign bus.ALUSrcA_o    = alu_src_a;
  assign bus.ALUSrcB_o    = alu_src_b;
  assign bus.ALUControl_o = alu_ctrl;
  assign bus.ImmSrc_o     = imm_src;
  assign bus.state_o      = cur_state;

endmodule

// File: doc/ucsbece154a_mccontroller.md
# ucsbece154a_mccontroller

Multicycle control unit for the ucsbece154a RISC-V core. It decodes `op_i`/`funct3_i`/`funct7b5_i` and steps a Moore state machine that drives the shared datapath through one instruction at a time: a single ALU, a single unified instruction/data memory port, and the PC, IR, OldPC, A, Data and ALUOut registers. It also waits on a memory-ready handshake, so slow memories stall the core cleanly. It sits beside the multicycle datapath in the top level.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: synchronous, active-low reset.
- `op_i` input 7: opcode from IR.
- `funct3_i` input 3: funct3 from IR.
- `funct7b5_i` input 1: IR bit 30.
- `zero_i` input 1: ALU zero flag.
- `memready_i` input 1: memory access completes this cycle.
- `PCWrite_o` output 1: PC register enable.
- `AdrSrc_o` output 1: memory address select (0 = PC, 1 = ALUOut).
- `MemWrite_o` output 1: memory write strobe.
- `IRWrite_o` output 1: IR and OldPC enable.
- `ResultSrc_o` output 2: result select (00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt).
- `ALUSrcA_o` output 2: ALU A select (00 PC, 01 OldPC, 10 A).
- `ALUSrcB_o` output 2: ALU B select (00 WriteData, 01 ImmExt, 10 constant 4).
- `ALUControl_o` output 3: `ALUcontrol_*` encoding from the shared defines.
- `ImmSrc_o` output 3: immediate format.
- `RegWrite_o` output 1: register file write enable.
- `state_o` output 4: current state, for debug.

## Operation
- State encoding: Fetch 0, Decode 1, MemAdr 2, MemRead 3, MemWB 4, MemWrite 5, ExecuteR 6, ExecuteI 7, ALUWB 8, BEQ 9, JAL 10, LUI 11. Encodings 12–15 are unreachable and return to Fetch.
- Per-state outputs (anything unlisted is 0 or 00):
  - Fetch: IRWrite = memready_i; PCUpdate = memready_i; ALUSrcB 10; ResultSrc 10; ALUOp 00.
  - Decode: ALUSrcA 01; ALUSrcB 01; ALUOp 00. This precomputes the branch target into ALUOut.
  - MemAdr: ALUSrcA 10; ALUSrcB 01; ALUOp 00.
  - MemRead: AdrSrc 1.
  - MemWrite: AdrSrc 1; MemWrite 1.
  - MemWB: ResultSrc 01; RegWrite 1.
  - ExecuteR: ALUSrcA 10; ALUSrcB 00; ALUOp 10.
  - ExecuteI: ALUSrcA 10; ALUSrcB 01; ALUOp 10.
  - ALUWB: RegWrite 1.
  - BEQ: ALUSrcA 10; ALUSrcB 00; ALUOp 01; Branch 1.
  - JAL: ALUSrcA 01; ALUSrcB 10; PCUpdate 1.
  - LUI: ResultSrc 11; RegWrite 1.
- `PCWrite_o = PCUpdate | (Branch & zero_i)`.
- Transitions:
  - Fetch → Decode when memready_i, else stay in Fetch.
  - Decode → MemAdr for lw/sw; ExecuteR for R-type; ExecuteI for I-type ALU; BEQ for opcode 1100011; JAL for jal; LUI for lui.
  - Decode → Fetch for any other opcode. The instruction retires as a NOP with PC already advanced.
  - MemAdr → MemRead for lw, MemWrite for sw.
  - MemRead → MemWB when memready_i, else hold.
  - MemWrite → Fetch when memready_i, else hold with MemWrite_o still asserted.
  - ExecuteR, ExecuteI and JAL → ALUWB.
  - MemWB, ALUWB, BEQ and LUI → Fetch.
- ImmSrc_o is combinational on op_i in every state: lw/I-type 000, sw 001, branch 010, jal 011, lui 100, other 000.
- ALU decode:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10 by funct3:
    - 000 → sub when `funct7b5_i & op_i[5]`, else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - other → add.

## Timing
- State register updates on the rising edge of clk. All outputs are combinational from state, op_i, funct3_i, funct7b5_i, zero_i and memready_i, with no registered outputs.
- Reset:
  - The reset_n low level is sampled on the edge; the next state is Fetch.
  - While reset_n is low, PCWrite_o, IRWrite_o, MemWrite_o and RegWrite_o are forced to 0.
  - All other outputs show Fetch values: ALUSrcB 10, ResultSrc 10, AdrSrc 0, ALUControl add, state_o 0.
- Reset mid-instruction, including mid-MemWrite wait, aborts the instruction. The next cycle is Fetch with no pending write.
- Latency with memready_i tied to 1:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq, lui: 3 cycles.
  - Unsupported opcode: 2 cycles.
- Each cycle memready_i is low in Fetch, MemRead or MemWrite adds one cycle.
- The handshake is level-based. The access completes on the edge where memready_i is 1, and strobes are qualified in that cycle only.

## Configuration
- `UCSBECE154A_BNE_EN` defined:
  - In the BEQ state, funct3 001 (bne) uses `Branch & ~zero_i`.
  - funct3 000 uses `Branch & zero_i`.
- Undefined:
  - BEQ always uses `Branch & zero_i` regardless of funct3, so bne behaves as beq.
- Latency is identical in both builds.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with memready_i=1 → state_o=0, all write enables 0. After release, PCWrite_o=1 and IRWrite_o=1 in the first cycle.
- add with op 0110011, funct3 000, funct7b5 0 → states 0,1,6,8,0; ALUControl add in ExecuteR; RegWrite_o=1 only in ALUWB. The same with funct7b5 1 gives sub.
- lw with memready_i low for 3 cycles in MemRead → states 0,1,2,3,3,3,3,4,0; AdrSrc_o=1 throughout MemRead; RegWrite_o asserted once.
- beq with zero_i=1 → PCWrite_o=1 in BEQ. With zero_i=0 → PCWrite_o=0.
- BNE build: funct3 001 with zero_i=0 → PCWrite_o=1 in BEQ. Default build: PCWrite_o=0 for the same stimulus.
- jal → states 0,1,10,8,0; ImmSrc_o=011; PCWrite_o=1 in JAL. Opcode 0000000 → states 0,1,0. reset_n=0 during sw's MemWrite → MemWrite_o=0 that cycle, then state 0.
